// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters and execute-stage mispredict detection.
// Optional statistics counters are enabled with the BRANCH_PRED_STATS_EN macro.
module branch_predictor #(
  parameter int unsigned INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_f,
  output logic        pred_taken_f,
  output logic [31:0] pred_target_f,
  input  logic        upd_en_e,
  input  logic [31:0] pc_e,
  input  logic        taken_e,
  input  logic [31:0] target_e,
  input  logic        pred_taken_e,
  output logic        mispredict_e,
  output logic [31:0] redirect_pc_e
`ifdef BRANCH_PRED_STATS_EN
  ,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
`endif
);

  localparam int unsigned ENTRIES  = 1 << INDEX_BITS;
  localparam int unsigned TAG_BITS = 32 - INDEX_BITS - 2;

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  logic [INDEX_BITS-1:0] f_idx;
  logic [TAG_BITS-1:0]   f_tag;
  logic [INDEX_BITS-1:0] e_idx;
  logic [TAG_BITS-1:0]   e_tag;
  logic                  e_hit;
  logic [1:0]            e_ctr_next;
  logic                  unused_pc_bits;

  assign f_idx = pc_f[INDEX_BITS+1:2];
  assign f_tag = pc_f[31:INDEX_BITS+2];
  assign e_idx = pc_e[INDEX_BITS+1:2];
  assign e_tag = pc_e[31:INDEX_BITS+2];

  // Byte-offset bits never participate in indexing or tagging.
  assign unused_pc_bits = ^{pc_f[1:0], pc_e[1:0]};

  // Fetch lookup sees pre-update table contents; no bypass from execute.
  always_comb begin
    pred_taken_f  = valid_q[f_idx] & (tag_q[f_idx] == f_tag) & ctr_q[f_idx][1];
    pred_target_f = pred_taken_f ? target_q[f_idx] : pc_f + 32'd4;
  end

  always_comb begin
    mispredict_e  = upd_en_e & (taken_e != pred_taken_e);
    redirect_pc_e = taken_e ? target_e : pc_e + 32'd4;
  end

  // Saturating counter step for an update hit.
  always_comb begin
    e_hit      = valid_q[e_idx] & (tag_q[e_idx] == e_tag);
    e_ctr_next = ctr_q[e_idx];
    if (taken_e) begin
      if (ctr_q[e_idx] != 2'b11) e_ctr_next = ctr_q[e_idx] + 2'd1;
    end else begin
      if (ctr_q[e_idx] != 2'b00) e_ctr_next = ctr_q[e_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        ctr_q[INDEX_BITS'(i)] <= 2'b01;
      end
    end else if (upd_en_e) begin
      if (e_hit) begin
        ctr_q[e_idx] <= e_ctr_next;
      end else if (taken_e) begin
        valid_q[e_idx] <= 1'b1;
        ctr_q[e_idx]   <= 2'b10;
      end
    end
  end

  // Tag/target need no reset; they are only meaningful behind a valid bit.
  always_ff @(posedge clk) begin
    if (reset && upd_en_e && taken_e) begin
      tag_q[e_idx]    <= e_tag;
      target_q[e_idx] <= target_e;
    end
  end

`ifdef BRANCH_PRED_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      if (upd_en_e)     br_count      <= br_count + 32'd1;
      if (mispredict_e) mispred_count <= mispred_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios then randomized traffic
// against a reference model that tracks, per table slot, the owning branch address.
module tb_branch_predictor;

  localparam int unsigned IB = 4;
  localparam int unsigned NE = 1 << IB;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_f;
  logic        pred_taken_f;
  logic [31:0] pred_target_f;
  logic        upd_en_e;
  logic [31:0] pc_e;
  logic        taken_e;
  logic [31:0] target_e;
  logic        pred_taken_e;
  logic        mispredict_e;
  logic [31:0] redirect_pc_e;
`ifdef BRANCH_PRED_STATS_EN
  logic [31:0] br_count;
  logic [31:0] mispred_count;
`endif

  branch_predictor #(.INDEX_BITS(IB)) dut (
    .clk(clk), .reset(reset), .pc_f(pc_f),
    .pred_taken_f(pred_taken_f), .pred_target_f(pred_target_f),
    .upd_en_e(upd_en_e), .pc_e(pc_e), .taken_e(taken_e),
    .target_e(target_e), .pred_taken_e(pred_taken_e),
    .mispredict_e(mispredict_e), .redirect_pc_e(redirect_pc_e)
`ifdef BRANCH_PRED_STATS_EN
    , .br_count(br_count), .mispred_count(mispred_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: which branch (word address) owns each slot, its target and confidence 0..3.
  bit          m_known = 0;
  bit          m_valid  [NE];
  logic [31:0] m_owner  [NE];
  logic [31:0] m_target [NE];
  int          m_conf   [NE];
  logic [31:0] m_br = 0;
  logic [31:0] m_mis = 0;

  logic        o_pt, o_mp;
  logic [31:0] o_tgt, o_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % NE);
  endfunction

  function automatic bit model_pred(input logic [31:0] pc);
    int s = slot(pc);
    return m_valid[s] && (m_owner[s] >> 2) == (pc >> 2) && m_conf[s] >= 2;
  endfunction

  // One clock: drive, check combinational outputs against the model, then advance model.
  task automatic cycle(input logic rst, input logic [31:0] pcf, input logic upd,
                       input logic [31:0] pce, input logic tk, input logic [31:0] tgt,
                       input logic ptk);
    logic exp_pt;
    @(negedge clk);
    reset = rst; pc_f = pcf; upd_en_e = upd; pc_e = pce;
    taken_e = tk; target_e = tgt; pred_taken_e = ptk;
    #1;
    o_pt = pred_taken_f; o_tgt = pred_target_f; o_mp = mispredict_e; o_rd = redirect_pc_e;
    if (m_known) begin
      exp_pt = model_pred(pcf);
      chk("pred_taken_f", 32'(o_pt), 32'(exp_pt));
      chk("pred_target_f", o_tgt, exp_pt ? m_target[slot(pcf)] : pcf + 32'd4);
`ifdef BRANCH_PRED_STATS_EN
      chk("br_count", br_count, m_br);
      chk("mispred_count", mispred_count, m_mis);
`endif
    end
    chk("mispredict_e", 32'(o_mp), 32'(upd && (tk != ptk)));
    if (upd && (tk != ptk)) chk("redirect_pc_e", o_rd, tk ? tgt : pce + 32'd4);
    @(posedge clk);
    if (!rst) begin
      m_known = 1;
      m_br = 0; m_mis = 0;
      for (int i = 0; i < NE; i++) begin m_valid[i] = 0; m_conf[i] = 1; end
    end else if (upd) begin
      int s = slot(pce);
      m_br++;
      if (tk != ptk) m_mis++;
      if (m_valid[s] && (m_owner[s] >> 2) == (pce >> 2)) begin
        m_conf[s] = tk ? (m_conf[s] < 3 ? m_conf[s] + 1 : 3) : (m_conf[s] > 0 ? m_conf[s] - 1 : 0);
        if (tk) m_target[s] = tgt;
      end else if (tk) begin
        m_valid[s] = 1; m_owner[s] = pce; m_target[s] = tgt; m_conf[s] = 2;
      end
    end
  endtask

  function automatic logic [31:0] rand_pc();
    return 32'h100 + 32'($urandom_range(0, 3) << 2) + 32'($urandom_range(0, 2) << 6);
  endfunction

  initial begin
    reset = 1'b0; pc_f = '0; upd_en_e = 1'b0; pc_e = '0;
    taken_e = 1'b0; target_e = '0; pred_taken_e = 1'b0;

    cycle(0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    cycle(0, 32'h0, 0, 32'h0, 0, 32'h0, 0);

    // Cold miss right after reset.
    cycle(1, 32'h100, 0, 32'h0, 0, 32'h0, 0);
    chk("cold_pt", 32'(o_pt), 32'd0);
    chk("cold_tgt", o_tgt, 32'h104);

    // Allocation, with same-cycle lookup still seeing the old (empty) entry.
    cycle(1, 32'h100, 1, 32'h100, 1, 32'h40, 0);
    chk("alloc_mp", 32'(o_mp), 32'd1);
    chk("alloc_rd", o_rd, 32'h40);
    chk("alloc_same_cycle_pt", 32'(o_pt), 32'd0);
    cycle(1, 32'h100, 0, 32'h0, 0, 32'h0, 0);
    chk("alloc_next_pt", 32'(o_pt), 32'd1);
    chk("alloc_next_tgt", o_tgt, 32'h40);

    // Saturation and hysteresis.
    for (int k = 0; k < 3; k++) cycle(1, 32'h100, 1, 32'h100, 1, 32'h40, 1);
    cycle(1, 32'h100, 1, 32'h100, 0, 32'h40, 1);
    cycle(1, 32'h100, 0, 32'h0, 0, 32'h0, 0);
    chk("hyst_still_taken", 32'(o_pt), 32'd1);
    cycle(1, 32'h100, 1, 32'h100, 0, 32'h40, 1);
    chk("hyst_rd", o_rd, 32'h104);
    chk("hyst_same_cycle_pt", 32'(o_pt), 32'd1);
    cycle(1, 32'h100, 0, 32'h0, 0, 32'h0, 0);
    chk("hyst_now_nt", 32'(o_pt), 32'd0);
    chk("hyst_now_nt_tgt", o_tgt, 32'h104);

    // Aliasing: 0x140 evicts 0x100 from the shared slot.
    cycle(1, 32'h100, 1, 32'h100, 1, 32'h40, 0);
    cycle(1, 32'h100, 1, 32'h140, 1, 32'h80, 0);
    chk("alias_before_pt", 32'(o_pt), 32'd1);
    cycle(1, 32'h100, 0, 32'h0, 0, 32'h0, 0);
    chk("alias_old_miss", 32'(o_pt), 32'd0);
    cycle(1, 32'h140, 0, 32'h0, 0, 32'h0, 0);
    chk("alias_new_pt", 32'(o_pt), 32'd1);
    chk("alias_new_tgt", o_tgt, 32'h80);

    // Reset has priority over a concurrent update.
    cycle(0, 32'h200, 1, 32'h200, 1, 32'h300, 0);
    cycle(1, 32'h200, 0, 32'h0, 0, 32'h0, 0);
    chk("rst_prio_pt", 32'(o_pt), 32'd0);
    cycle(1, 32'h140, 0, 32'h0, 0, 32'h0, 0);
    chk("rst_cleared_pt", 32'(o_pt), 32'd0);

`ifdef BRANCH_PRED_STATS_EN
    // Five updates, two of them mispredicted, counted from a fresh reset.
    cycle(0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    cycle(1, 32'h0, 1, 32'h100, 1, 32'h40, 0);
    cycle(1, 32'h0, 1, 32'h100, 1, 32'h40, 1);
    cycle(1, 32'h0, 1, 32'h100, 0, 32'h40, 0);
    cycle(1, 32'h0, 1, 32'h104, 0, 32'h40, 1);
    cycle(1, 32'h0, 1, 32'h108, 1, 32'h40, 1);
    cycle(1, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    chk("stats_br", br_count, 32'd5);
    chk("stats_mis", mispred_count, 32'd2);
`endif

    // Randomized traffic over a small aliasing-prone address pool.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pf, pe, tg;
      logic up, tk, ptk, rs;
      pf  = rand_pc();
      pe  = rand_pc();
      tg  = $urandom & 32'hFFFF_FFFC;
      up  = ($urandom_range(0, 3) != 0);
      tk  = 1'($urandom);
      ptk = ($urandom_range(0, 1) != 0) ? model_pred(pe) : 1'($urandom);
      rs  = ($urandom_range(0, 49) != 0);
      if (!up) begin tk = 1'($urandom); ptk = 1'($urandom); end
      cycle(rs, pf, up, pe, tk, tg, ptk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
